// File: rtl/bitstream_unpacker.sv
// Unpacks BUS_WIDTH-bit stream words into an MSB-first bit window for an entropy decoder.
// A left-aligned double-width buffer absorbs variable-length consumes and frame-end padding.
module bitstream_unpacker #(
  parameter int unsigned BUS_WIDTH = 64,
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [BUS_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [MAX_LEN-1:0]   m_bits,
  output logic [CNT_W-1:0]     m_count,
  output logic                 m_last,
  input  logic                 consume,
  input  logic [CNT_W-1:0]     consume_len,
  input  logic                 flush,
  output logic                 err
);

  localparam int unsigned BUF_W  = 2 * BUS_WIDTH;
  localparam int unsigned FILL_W = $clog2(BUF_W + 1);
  localparam int unsigned NBYTES = BUS_WIDTH / 8;

  logic [BUF_W-1:0]     bits_q, bits_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;
  logic [BUS_WIDTH-1:0] word_be;
  logic                 load;

  // Byte 0 of the bus word is first in the stream, so it moves to the MSB end.
  always_comb begin
    word_be = '0;
    for (int k = 0; k < NBYTES; k++) begin
      word_be[BUS_WIDTH-1-8*k -: 8] = s_axis_tdata[8*k +: 8];
    end
  end

  assign s_axis_tready = (fill_q <= FILL_W'(BUS_WIDTH)) && !last_q;
  assign load          = s_axis_tvalid && s_axis_tready;
  assign m_bits        = bits_q[BUF_W-1 -: MAX_LEN];
  assign m_count       = (fill_q < FILL_W'(MAX_LEN)) ? CNT_W'(fill_q) : CNT_W'(MAX_LEN);
  assign m_last        = last_q && (fill_q <= FILL_W'(MAX_LEN));
  assign err           = err_q;

  // Bits beyond fill are kept at zero so the window needs no masking.
  always_comb begin
    bits_d = bits_q;
    fill_d = fill_q;
    last_d = last_q;
    err_d  = err_q;
    if (flush) begin
      bits_d = '0;
      fill_d = '0;
      last_d = 1'b0;
    end else if (consume) begin
      if (consume_len > m_count) begin
        err_d = 1'b1;
      end else begin
        bits_d = bits_q << consume_len;
        fill_d = fill_q - FILL_W'(consume_len);
        if (last_q && (fill_d == '0)) begin
          last_d = 1'b0;
        end
      end
    end
    if (load) begin
      bits_d = bits_d | ({word_be, {BUS_WIDTH{1'b0}}} >> fill_d);
      fill_d = fill_d + FILL_W'(BUS_WIDTH);
      if (s_axis_tlast) begin
        last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      bits_q <= '0;
      fill_q <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      bits_q <= bits_d;
      fill_q <= fill_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_bitstream_unpacker.sv
// Directed and randomised checks of bitstream_unpacker against a bit-serial queue model.
module tb_bitstream_unpacker;

  localparam int unsigned BW = 64;
  localparam int unsigned ML = 32;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [BW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [ML-1:0] m_bits;
  logic [CW-1:0] m_count;
  logic          m_last;
  logic          consume;
  logic [CW-1:0] consume_len;
  logic          flush;
  logic          err;

  int checks   = 0;
  int failures = 0;

  // Bit-serial reference: queue holds stream bits oldest first.
  bit mq[$];
  bit mlast;
  bit merr;

  always #5 clk = ~clk;

  bitstream_unpacker #(.BUS_WIDTH(BW), .MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_bits(m_bits), .m_count(m_count), .m_last(m_last),
    .consume(consume), .consume_len(consume_len), .flush(flush), .err(err)
  );

  function automatic logic [31:0] exp_bits();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[31-i] = (i < mq.size()) ? mq[i] : 1'b0;
    return r;
  endfunction

  function automatic int exp_count();
    return (mq.size() < 32) ? mq.size() : 32;
  endfunction

  function automatic logic exp_tready();
    return (mq.size() <= 64) && !mlast;
  endfunction

  task automatic model_step(input logic f, input logic c, input logic [7:0] len,
                            input logic v, input logic [63:0] d, input logic t);
    logic hs;
    hs = v && exp_tready();
    if (f) begin
      mq.delete();
      mlast = 1'b0;
    end else if (c) begin
      if (int'(len) > exp_count()) merr = 1'b1;
      else begin
        for (int i = 0; i < int'(len); i++) void'(mq.pop_front());
        if (mlast && mq.size() == 0) mlast = 1'b0;
      end
    end
    if (hs) begin
      for (int k = 0; k < 8; k++)
        for (int b = 7; b >= 0; b--) mq.push_back(d[8*k+b]);
      if (t) mlast = 1'b1;
    end
  endtask

  // One clock: drive inputs, advance model, sample 1ns after the edge.
  task automatic cyc(input logic f, input logic c, input logic [7:0] len,
                     input logic v, input logic [63:0] d, input logic t);
    flush = f; consume = c; consume_len = len;
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = t;
    model_step(f, c, len, v, d, t);
    @(posedge clk);
    #1;
    flush = 1'b0; consume = 1'b0; consume_len = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    mq.delete(); mlast = 1'b0; merr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    flush = 0; consume = 0; consume_len = 0; s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tlast = 0;
    do_reset();
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_tready got=%0b exp=1", s_axis_tready); end
    checks++; if (m_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", m_count); end
    checks++; if (m_bits !== 32'h0) begin failures++; $display("FAIL reset_bits got=%h exp=0", m_bits); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b exp=0", m_last); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
  endtask

  task automatic test_load();
    cyc(0, 0, 0, 1, 64'h0000_0000_0000_80FF, 0);
    checks++; if (m_bits !== 32'hFF80_0000) begin failures++; $display("FAIL load_bits got=%h exp=ff800000", m_bits); end
    checks++; if (m_count !== 8'd32) begin failures++; $display("FAIL load_count got=%0d exp=32", m_count); end
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL load_tready got=%0b exp=1", s_axis_tready); end
    cyc(1, 0, 0, 0, 0, 0);
    checks++; if (m_count !== 8'd0) begin failures++; $display("FAIL load_flush_count got=%0d exp=0", m_count); end
  endtask

  task automatic test_consume5();
    cyc(0, 0, 0, 1, 64'h0123_4567_89AB_F0A5, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 8'd5, 0, 0, 0);
      if (i == 0) begin
        checks++; if (m_bits !== 32'hBE15_712C) begin failures++; $display("FAIL c5_first got=%h exp=be15712c", m_bits); end
      end
      checks++; if (m_bits !== exp_bits()) begin failures++; $display("FAIL c5_bits[%0d] got=%h exp=%h", i, m_bits, exp_bits()); end
      checks++; if (int'(m_count) != exp_count()) begin failures++; $display("FAIL c5_count[%0d] got=%0d exp=%0d", i, m_count, exp_count()); end
    end
    checks++; if (m_count !== 8'd4) begin failures++; $display("FAIL c5_tail got=%0d exp=4", m_count); end
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    cyc(0, 0, 0, 1, 64'h1111_2222_3333_4444, 0);
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL b2b_tready1 got=%0b exp=1", s_axis_tready); end
    cyc(0, 0, 0, 1, 64'h5555_6666_7777_8888, 0);
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL b2b_tready2 got=%0b exp=0", s_axis_tready); end
    checks++; if (m_bits !== 32'h4444_3333) begin failures++; $display("FAIL b2b_bits got=%h exp=44443333", m_bits); end
    cyc(0, 1, 8'd32, 0, 0, 0);
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL b2b_tready96 got=%0b exp=0", s_axis_tready); end
    checks++; if (m_bits !== 32'h2222_1111) begin failures++; $display("FAIL b2b_bits96 got=%h exp=22221111", m_bits); end
    cyc(0, 1, 8'd32, 0, 0, 0);
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL b2b_tready64 got=%0b exp=1", s_axis_tready); end
    checks++; if (m_bits !== 32'h8888_7777) begin failures++; $display("FAIL b2b_bits64 got=%h exp=88887777", m_bits); end
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_frame_end();
    cyc(0, 0, 0, 1, 64'hDEAD_BEEF_1234_5678, 1);
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL fe_tready got=%0b exp=0", s_axis_tready); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL fe_last64 got=%0b exp=0", m_last); end
    cyc(0, 1, 8'd32, 0, 0, 0);
    checks++; if (m_last !== 1'b1) begin failures++; $display("FAIL fe_last32 got=%0b exp=1", m_last); end
    checks++; if (m_count !== 8'd32) begin failures++; $display("FAIL fe_count32 got=%0d exp=32", m_count); end
    cyc(1, 0, 0, 0, 0, 0);
    checks++; if (m_last !== 1'b0 || m_count !== 8'd0 || s_axis_tready !== 1'b1) begin
      failures++; $display("FAIL fe_flush got last=%0b count=%0d tready=%0b exp 0/0/1", m_last, m_count, s_axis_tready); end
    cyc(0, 0, 0, 1, 64'h0000_0000_0000_0080, 1);
    checks++; if (m_bits !== 32'h8000_0000) begin failures++; $display("FAIL fe_next_bits got=%h exp=80000000", m_bits); end
    cyc(0, 1, 8'd32, 0, 0, 0);
    cyc(0, 1, 8'd32, 0, 0, 0);
    checks++; if (s_axis_tready !== 1'b1 || m_last !== 1'b0 || m_count !== 8'd0) begin
      failures++; $display("FAIL fe_autoclear got tready=%0b last=%0b count=%0d exp 1/0/0", s_axis_tready, m_last, m_count); end
  endtask

  task automatic test_flush_load();
    cyc(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    cyc(0, 1, 8'd8, 0, 0, 0);
    cyc(1, 1, 8'd8, 1, 64'h0000_0000_1122_33C3, 0);
    checks++; if (m_bits !== 32'hC333_2211) begin failures++; $display("FAIL fl_bits got=%h exp=c3332211", m_bits); end
    checks++; if (m_count !== 8'd32 || s_axis_tready !== 1'b1) begin
      failures++; $display("FAIL fl_state got count=%0d tready=%0b exp 32/1", m_count, s_axis_tready); end
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_over_consume();
    cyc(0, 0, 0, 1, 64'h0F0F_0F0F_0F0F_0F0F, 0);
    cyc(0, 1, 8'd32, 0, 0, 0);
    cyc(0, 1, 8'd22, 0, 0, 0);
    checks++; if (m_count !== 8'd10 || err !== 1'b0) begin
      failures++; $display("FAIL oc_pre got count=%0d err=%0b exp 10/0", m_count, err); end
    cyc(0, 1, 8'd11, 0, 0, 0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oc_err got=%0b exp=1", err); end
    checks++; if (m_count !== 8'd10) begin failures++; $display("FAIL oc_count got=%0d exp=10", m_count); end
    cyc(0, 1, 8'd0, 0, 0, 0);
    checks++; if (m_count !== 8'd10 || err !== 1'b1) begin
      failures++; $display("FAIL oc_zero got count=%0d err=%0b exp 10/1", m_count, err); end
    do_reset();
    checks++; if (err !== 1'b0 || m_count !== 8'd0) begin
      failures++; $display("FAIL oc_reset got err=%0b count=%0d exp 0/0", err, m_count); end
  endtask

  task automatic test_random();
    for (int fr = 0; fr < 2; fr++) begin
      logic [63:0] words[$];
      bit          expq[$];
      bit          got[$];
      int          nw, sent, flushed;
      bit          done;
      logic        f, c, v, t;
      logic [7:0]  len;
      nw = 3 + fr; sent = 0; flushed = 0; done = 0;
      for (int w = 0; w < nw; w++) begin
        words.push_back({$urandom, $urandom});
        for (int k = 0; k < 8; k++)
          for (int b = 7; b >= 0; b--) expq.push_back(words[w][8*k+b]);
      end
      for (int n = 0; n < 2000 && !done; n++) begin
        v = (sent < nw) && ($urandom_range(0, 3) != 0);
        t = (sent == nw - 1);
        f = 0; c = 0; len = 0;
        if (mlast && mq.size() <= 32 && $urandom_range(0, 2) == 0) begin
          f = 1; flushed = mq.size();
        end else if (mq.size() > 0) begin
          c = 1; len = 8'($urandom_range(0, exp_count()));
          for (int i = 0; i < int'(len); i++) got.push_back(m_bits[31-i]);
        end
        if (v && exp_tready()) begin
          cyc(f, c, len, v, words[sent], t);
          sent++;
        end else begin
          cyc(f, c, len, v, (sent < nw) ? words[sent] : 64'h0, t);
        end
        checks++; if (m_bits !== exp_bits() || int'(m_count) != exp_count()) begin
          failures++; $display("FAIL rnd_window f%0d n%0d got=%h/%0d exp=%h/%0d", fr, n, m_bits, m_count, exp_bits(), exp_count()); end
        checks++; if (s_axis_tready !== exp_tready() || m_last !== (mlast && mq.size() <= 32) || err !== merr) begin
          failures++; $display("FAIL rnd_ctrl f%0d n%0d got tready=%0b last=%0b err=%0b", fr, n, s_axis_tready, m_last, err); end
        done = (sent == nw) && (mq.size() == 0) && !mlast;
      end
      checks++; if (!done) begin failures++; $display("FAIL rnd_timeout frame=%0d sent=%0d", fr, sent); end
      checks++; if (got.size() + flushed != expq.size()) begin
        failures++; $display("FAIL rnd_len frame=%0d got=%0d exp=%0d", fr, got.size() + flushed, expq.size()); end
      else begin
        int bad;
        bad = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] != expq[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL rnd_stream frame=%0d bad_bits=%0d exp=0", fr, bad); end
      end
    end
  endtask

  initial begin
    aresetn = 1'b1;
    mlast = 1'b0; merr = 1'b0;
    test_reset();
    test_load();
    test_consume5();
    test_back_to_back();
    test_frame_end();
    test_flush_load();
    test_over_consume();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
